// File: rtl/bk_load_store_unit.sv
// bk_load_store_unit: single-outstanding load/store front-end for a 256 x 2*WIDTH memory.
// Define BKLSU_RMW_EN to build partial-lane stores as read-modify-write.
module bk_load_store_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reqValid,
  output logic               reqReady,
  input  logic               reqWrite,
  input  logic [1:0]         reqByteEn,
  input  logic [WIDTH-1:0]   reqAddress,
  input  logic [2*WIDTH-1:0] reqWriteData,
  output logic               rspValid,
  input  logic               rspReady,
  output logic [2*WIDTH-1:0] rspData,
  output logic               rspError,
  output logic [15:0]        txnCount,
  output logic               memoryRead,
  output logic               memoryWrite,
  output logic [WIDTH-1:0]   memoryAddress,
  output logic [2*WIDTH-1:0] memoryWriteData,
  input  logic [2*WIDTH-1:0] memoryOutData
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RMW_READ,
    RMW_WRITE,
    RESP
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   addr;
  logic [2*WIDTH-1:0] wdata;
  logic [2*WIDTH-1:0] rsp_data;
  logic               rsp_error;
  logic [15:0]        txn_count;
  logic               in_write;
  logic               in_read;

`ifdef BKLSU_RMW_EN
  logic [1:0] byte_en;

  function automatic logic [2*WIDTH-1:0] merge(
    input logic [1:0]         be,
    input logic [2*WIDTH-1:0] nw,
    input logic [2*WIDTH-1:0] old
  );
    logic [2*WIDTH-1:0] m;
    m = old;
    if (be[0]) m[WIDTH-1:0] = nw[WIDTH-1:0];
    if (be[1]) m[2*WIDTH-1:WIDTH] = nw[2*WIDTH-1:WIDTH];
    return m;
  endfunction
`endif

  assign in_read  = (state == READ) || (state == RMW_READ);
  assign in_write = (state == WRITE) || (state == RMW_WRITE);

  assign reqReady        = (state == IDLE);
  assign rspValid        = (state == RESP);
  assign rspData         = rsp_data;
  assign rspError        = rsp_error;
  assign txnCount        = txn_count;
  assign memoryAddress   = addr;
  // strobes are killed while reset is asserted so the reset edge never writes
  assign memoryRead      = rst_n && in_read;
  assign memoryWrite     = rst_n && in_write;
  assign memoryWriteData = in_write ? wdata : '0;

  // transaction sequencer: latch request, drive memory phases, hold response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      txn_count <= '0;
`ifdef BKLSU_RMW_EN
      byte_en   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (reqValid) begin
            addr      <= reqAddress;
            wdata     <= reqWriteData;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
`ifdef BKLSU_RMW_EN
            byte_en   <= reqByteEn;
`endif
            if (!reqWrite) begin
              state <= READ;
            end else if (reqByteEn == 2'b11) begin
              state <= WRITE;
            end else if (reqByteEn == 2'b00) begin
              state <= RESP;
            end else begin
`ifdef BKLSU_RMW_EN
              state <= RMW_READ;
`else
              rsp_error <= 1'b1;
              state     <= RESP;
`endif
            end
          end
        end
        READ: begin
          rsp_data <= memoryOutData;
          state    <= RESP;
        end
        WRITE: begin
          state <= RESP;
        end
`ifdef BKLSU_RMW_EN
        RMW_READ: begin
          wdata <= merge(byte_en, wdata, memoryOutData);
          state <= RMW_WRITE;
        end
        RMW_WRITE: begin
          state <= RESP;
        end
`endif
        RESP: begin
          if (rspReady) begin
            txn_count <= txn_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bk_load_store_unit.sv
// tb_bk_load_store_unit: random + directed bench with a transaction-level memory model.
// Build with BKLSU_RMW_EN defined to match an RMW-enabled design.
module tb_bk_load_store_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         reqValid = 1'b0;
  logic         reqReady;
  logic         reqWrite = 1'b0;
  logic [1:0]   reqByteEn = '0;
  logic [W-1:0] reqAddress = '0;
  logic [15:0]  reqWriteData = '0;
  logic         rspValid;
  logic         rspReady = 1'b0;
  logic [15:0]  rspData;
  logic         rspError;
  logic [15:0]  txnCount;
  logic         memoryRead;
  logic         memoryWrite;
  logic [W-1:0] memoryAddress;
  logic [15:0]  memoryWriteData;
  logic [15:0]  memoryOutData;

  logic [15:0] mem [256] = '{default: '0};

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] wd;
  } step_t;

  logic [15:0] ref_mem [256] = '{default: '0};
  step_t       q [$];
  bit          m_pending = 1'b0;
  logic [15:0] m_data = '0;
  bit          m_err = 1'b0;
  logic [15:0] m_count = '0;
  logic [7:0]  m_addr = '0;
  bit          preload = 1'b0;
  bit          chk_on = 1'b0;

  int vecs = 0;
  int errs = 0;

  bk_load_store_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqWrite(reqWrite),
    .reqByteEn(reqByteEn),
    .reqAddress(reqAddress),
    .reqWriteData(reqWriteData),
    .rspValid(rspValid),
    .rspReady(rspReady),
    .rspData(rspData),
    .rspError(rspError),
    .txnCount(txnCount),
    .memoryRead(memoryRead),
    .memoryWrite(memoryWrite),
    .memoryAddress(memoryAddress),
    .memoryWriteData(memoryWriteData),
    .memoryOutData(memoryOutData)
  );

  always #5 clk = ~clk;

  assign memoryOutData = mem[memoryAddress];

  // data memory: combinational read, write on the clock edge
  always @(posedge clk) begin
    if (memoryWrite) mem[memoryAddress] <= memoryWriteData;
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // reference model: one transaction becomes a list of memory cycles
  always @(posedge clk) begin
    step_t s;
    logic [15:0] nw;
    if (preload) m_count = 16'hFFFF;
    if (!rst_n) begin
      q.delete();
      m_pending = 1'b0;
      m_data = '0;
      m_err = 1'b0;
      m_count = '0;
      m_addr = '0;
    end else if (q.size() != 0) begin
      s = q.pop_front();
      if (s.wr) ref_mem[m_addr] = s.wd;
    end else if (m_pending) begin
      if (rspReady) begin
        m_pending = 1'b0;
        m_count = m_count + 16'd1;
      end
    end else if (reqValid) begin
      m_addr = reqAddress;
      m_pending = 1'b1;
      m_data = '0;
      m_err = 1'b0;
      if (!reqWrite) begin
        m_data = ref_mem[reqAddress];
        q.push_back(step_t'{1'b1, 1'b0, 16'h0});
      end else if (reqByteEn == 2'b11) begin
        q.push_back(step_t'{1'b0, 1'b1, reqWriteData});
      end else if (reqByteEn != 2'b00) begin
`ifdef BKLSU_RMW_EN
        nw = ref_mem[reqAddress];
        if (reqByteEn[0]) nw[7:0] = reqWriteData[7:0];
        if (reqByteEn[1]) nw[15:8] = reqWriteData[15:8];
        q.push_back(step_t'{1'b1, 1'b0, 16'h0});
        q.push_back(step_t'{1'b0, 1'b1, nw});
`else
        nw = '0;
        m_err = 1'b1;
`endif
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    bit erd, ewr, ersp;
    logic [15:0] ewd;
    if (chk_on) begin
      if (!rst_n) begin
        chk("rd_in_reset", memoryRead, 0);
        chk("wr_in_reset", memoryWrite, 0);
      end else begin
        erd  = q.size() != 0 && q[0].rd;
        ewr  = q.size() != 0 && q[0].wr;
        ewd  = ewr ? q[0].wd : 16'h0;
        ersp = m_pending && q.size() == 0;
        chk("reqReady", reqReady, !m_pending);
        chk("rspValid", rspValid, ersp);
        if (ersp) begin
          chk("rspData", rspData, m_data);
          chk("rspError", rspError, m_err);
        end
        chk("txnCount", txnCount, m_count);
        chk("memRead", memoryRead, erd);
        chk("memWrite", memoryWrite, ewr);
        chk("memWData", memoryWriteData, ewd);
        chk("memAddr", memoryAddress, m_addr);
      end
    end
  end

  task automatic noise();
    reqValid     = 1'($urandom);
    reqWrite     = 1'($urandom);
    reqByteEn    = 2'($urandom);
    reqAddress   = 8'($urandom);
    reqWriteData = 16'($urandom);
  endtask

  task automatic txn(input bit w, input logic [1:0] be,
                     input logic [7:0] a, input logic [15:0] d,
                     input int stall, output logic [15:0] rd,
                     output logic re);
    int guard;
    guard = 0;
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = w;
    reqByteEn = be;
    reqAddress = a;
    reqWriteData = d;
    @(negedge clk);
    noise();
    while (!rspValid && guard < 16) begin
      @(negedge clk);
      noise();
      guard++;
    end
    if (!rspValid) begin
      vecs++;
      errs++;
      $display("FAIL rsp_timeout: got no rspValid, expected one for addr %0h", a);
    end
    rd = rspData;
    re = rspError;
    repeat (stall) begin
      @(negedge clk);
      noise();
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    reqValid = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    logic re;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_reqReady", reqReady, 1);
    chk("rst_rspValid", rspValid, 0);
    chk("rst_rspData", rspData, 0);
    chk("rst_rspError", rspError, 0);
    chk("rst_txnCount", txnCount, 0);
    chk("rst_memRead", memoryRead, 0);
    chk("rst_memWrite", memoryWrite, 0);
    chk("rst_memAddr", memoryAddress, 0);
    chk("rst_memWData", memoryWriteData, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    txn(1, 2'b11, 8'h10, 16'hBEEF, 0, rd, re);
    chk("store_beef_err", re, 0);
    chk("store_beef_data", rd, 0);
    txn(0, 2'b00, 8'h10, 16'h0, 0, rd, re);
    chk("load_beef", rd, 16'hBEEF);
    chk("count_two", txnCount, 2);

    txn(1, 2'b11, 8'h20, 16'h1234, 0, rd, re);
    txn(1, 2'b10, 8'h20, 16'hAB00, 0, rd, re);
    txn(0, 2'b00, 8'h20, 16'h0, 0, rd, re);
`ifdef BKLSU_RMW_EN
    chk("partial_load", rd, 16'hAB34);
`else
    chk("partial_load", rd, 16'h1234);
`endif

    txn(0, 2'b00, 8'h10, 16'h0, 5, rd, re);
    chk("stall_load", rd, 16'hBEEF);

    txn(1, 2'b11, 8'hFF, 16'hC3A5, 0, rd, re);
    txn(0, 2'b00, 8'hFF, 16'h0, 0, rd, re);
    chk("load_ff", rd, 16'hC3A5);
    txn(1, 2'b00, 8'h10, 16'hFFFF, 0, rd, re);
    chk("noop_err", re, 0);
    txn(0, 2'b00, 8'h10, 16'h0, 0, rd, re);
    chk("noop_keeps", rd, 16'hBEEF);

    txn(1, 2'b11, 8'h30, 16'h0A0A, 0, rd, re);
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqByteEn = 2'b11;
    reqAddress = 8'h30;
    reqWriteData = 16'h5555;
    @(negedge clk);
    reqValid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem", mem[8'h30], 16'h0A0A);
    chk("rst_mid_count", txnCount, 0);
    chk("rst_mid_norsp", rspValid, 0);
    txn(0, 2'b00, 8'h30, 16'h0, 0, rd, re);
    chk("rst_mid_load", rd, 16'h0A0A);

    for (int i = 0; i < 250; i++) begin
      logic [7:0] a;
      a = (i % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      txn(1'($urandom), 2'($urandom), a, 16'($urandom),
          $urandom_range(0, 3), rd, re);
    end

    @(negedge clk);
    chk_on = 1'b0;
    force dut.txn_count = 16'hFFFF;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    release dut.txn_count;
    @(negedge clk);
    chk_on = 1'b1;
    chk("count_preload", txnCount, 16'hFFFF);
    txn(1, 2'b00, 8'h01, 16'h0, 0, rd, re);
    chk("count_wrap", txnCount, 16'h0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bk_load_store_unit.md
# bk_load_store_unit

Load/store front-end sitting directly upstream of the 256-entry, 2*WIDTH-bit processor data memory. It accepts one request at a time from the core over a valid/ready handshake. It sequences the memory strobes: combinational read, write taken on the clock edge. It returns read data, or a write completion, over a response valid/ready handshake. Optionally it performs byte-lane stores by read-modify-write.

## Interface
- WIDTH, 8, byte width; memory word is 2*WIDTH, address is WIDTH bits
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- reqValid  input  1  core request valid
- reqReady  output  1  unit can accept a request (IDLE only)
- reqWrite  input  1  1 = store, 0 = load
- reqByteEn  input  2  store lane enables; bit0 = [WIDTH-1:0], bit1 = [2*WIDTH-1:WIDTH]; ignored for loads
- reqAddress  input  WIDTH  word address
- reqWriteData  input  2*WIDTH  store data
- rspValid  output  1  response valid, held until rspReady
- rspReady  input  1  core accepts response
- rspData  output  2*WIDTH  load data; 0 for stores
- rspError  output  1  store rejected (partial lanes without RMW)
- txnCount  output  16  completed responses, wraps 0xFFFF->0
- memoryRead  output  1  memory read strobe
- memoryWrite  output  1  memory write strobe
- memoryAddress  output  WIDTH  memory address
- memoryWriteData  output  2*WIDTH  memory write data
- memoryOutData  input  2*WIDTH  memory combinational read data

## Operation
- States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP.
- IDLE: reqReady=1. A handshake (reqValid&reqReady) latches address, write data, byteEn and write flag, then branches:
  - load -> READ
  - store with byteEn=11 -> WRITE
  - store with byteEn=01/10 -> RMW_READ if RMW is compiled in, else RESP with rspError=1
  - store with byteEn=00 -> RESP with rspError=0 and no memory access
- READ: memoryRead=1. memoryOutData is registered into rspData at the clock edge. -> RESP.
- WRITE: memoryWrite=1, memoryWriteData = latched data. -> RESP.
- RMW_READ: memoryRead=1. Captures memoryOutData, then merges: enabled lanes from latched data, the other lanes from memory. -> RMW_WRITE.
- RMW_WRITE: memoryWrite=1 with the merged word. -> RESP.
- RESP: rspValid=1. rspData and rspError are stable. On rspReady: txnCount += 1 and -> IDLE. No new request is accepted in the same cycle.
- memoryAddress is always the latched address and holds after a transaction. memoryRead and memoryWrite are 0 outside their states. memoryWriteData is 0 outside WRITE and RMW_WRITE.
- Store responses drive rspData=0. Loads always drive rspError=0.

## Timing
- Reset values: state IDLE, reqReady=1, rspValid=0, rspData=0, rspError=0, txnCount=0, memoryRead=0, memoryWrite=0, memoryAddress=0, memoryWriteData=0.
- Request accepted at edge N. Load or full store: rspValid from cycle N+1 to N+2 (edge N+2). RMW store: rspValid at edge N+3. Rejected or no-op store: rspValid at edge N+1.
- Back-to-back throughput: a new request is accepted no earlier than the cycle after the rspReady handshake.
- rspReady held low stalls in RESP indefinitely. Outputs are frozen and memory strobes stay 0.
- rst_n low: memoryRead and memoryWrite are gated to 0 combinationally in that cycle, so no memory write happens at the reset edge. Any in-flight transaction is dropped with no response.
- reqValid in any non-IDLE state is ignored (reqReady=0).

## Configuration
- BKLSU_RMW_EN defined: partial-lane stores take RMW_READ and RMW_WRITE; rspError is never 1.
- Not defined: RMW states are absent. Partial-lane stores return rspError=1 and leave memory unchanged.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> every output at its reset value and txnCount=0.
- Full store then load: store addr 0x10, data 0xBEEF, byteEn=11; then load 0x10 -> rspData=0xBEEF, rspValid two cycles after each accept, txnCount=2.
- Partial store: memory[0x20]=0x1234; store 0xAB00 with byteEn=10 -> with BKLSU_RMW_EN, a load of 0x20 returns 0xAB34; without it, rspError=1 and the load returns 0x1234.
- Response backpressure: load with rspReady=0 for 5 cycles -> rspValid and rspData stable, reqReady=0, memoryRead=0, and txnCount increments only on release.
- Reset mid-store: assert rst_n=0 during the WRITE cycle of a store 0x5555 to 0x30 -> memory[0x30] is unchanged and no response is issued.
- Address wrap and counter wrap: load 0xFF returns the stored value; preload txnCount via 65535 transactions (or a force) -> the next response wraps it to 0.
